// File: rtl/sdram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter_pkg
// Shared timing/width definitions for the SDRAM port arbiter:
//   - default SDRAM data and word-address widths
//   - watchdog counter width and its largest legal limit
//   - arbiter FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_port_arbiter_pkg;

    localparam int SDRAM_DATA_WIDTH = 16;
    localparam int SDRAM_ADDR_WIDTH = 24;

    // Watchdog counter is fixed at 10 bits; the limit must fit in it.
    localparam int WDOG_W   = 10;
    localparam int WDOG_MAX = (1 << WDOG_W) - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_BUSY = 3'd2,
        RD_REQ  = 3'd3,
        RD_BUSY = 3'd4,
        DONE    = 3'd5
    } arb_state_t;

    // True in every state that belongs to a granted burst (watchdog runs here).
    function automatic logic is_burst_state(input arb_state_t s);
        return (s == WR_REQ) || (s == WR_BUSY) || (s == RD_REQ) || (s == RD_BUSY);
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// -----------------------------------------------------------------------------
// sdram_rr_pick
// Two-requester round-robin picker. The pointer names the channel that has
// priority this round; if that channel is idle the other one wins.
// Ports:
//   req [1:0]  request levels, bit N = channel N
//   ptr        priority pointer (channel favoured this round)
//   gnt [1:0]  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module sdram_rr_pick
    import sdram_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        // Win if requesting and either favoured or the other side is quiet.
        assign gnt[gi] = req[gi] && ((ptr == 1'(gi)) || !req[1 - gi]);
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Arbitrates two write channels and two read channels onto one SDRAM
// controller port. Writes beat reads; within each type a round-robin pointer
// alternates the channels. One burst at a time: grant, request, wait for the
// controller ack to fall, one DONE cycle, back to IDLE. A watchdog aborts a
// burst that hangs and raises a sticky timeout_err.
// Ports:
//   clk_ref, rst_n                 clock, asynchronous active-low reset
//   sdram_init_done                new grants only while high
//   chN_wr_req/addr/din, chN_wr_ack    write channels (ack is combinational)
//   chN_rd_req/addr, chN_rd_ack, chN_dout  read channels (dout broadcast)
//   sdram_wr_* / sdram_rd_*        controller side
//   timeout_err                    sticky watchdog flag
// -----------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int DATA_W = SDRAM_DATA_WIDTH,
    parameter int ADDR_W = SDRAM_ADDR_WIDTH,
    parameter int TO_CYC = 1023
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              sdram_init_done,

    input  logic              ch0_wr_req,
    input  logic [ADDR_W-1:0] ch0_wr_addr,
    input  logic [DATA_W-1:0] ch0_din,
    output logic              ch0_wr_ack,
    input  logic              ch1_wr_req,
    input  logic [ADDR_W-1:0] ch1_wr_addr,
    input  logic [DATA_W-1:0] ch1_din,
    output logic              ch1_wr_ack,

    input  logic              ch0_rd_req,
    input  logic [ADDR_W-1:0] ch0_rd_addr,
    output logic              ch0_rd_ack,
    output logic [DATA_W-1:0] ch0_dout,
    input  logic              ch1_rd_req,
    input  logic [ADDR_W-1:0] ch1_rd_addr,
    output logic              ch1_rd_ack,
    output logic [DATA_W-1:0] ch1_dout,

    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [DATA_W-1:0] sdram_din,

    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic [DATA_W-1:0] sdram_dout,

    output logic              timeout_err
);

    // The watchdog counter is only WDOG_W bits wide.
    if (TO_CYC > WDOG_MAX) begin : g_bad_to_cyc
        $error("sdram_port_arbiter: TO_CYC exceeds the 10-bit watchdog range");
    end

    localparam logic [WDOG_W-1:0] TO_LIMIT = WDOG_W'(TO_CYC);

    arb_state_t        state_reg, state_next;
    logic              wr_ch_reg;       // channel of the last write grant
    logic              rd_ch_reg;       // channel of the last read grant
    logic              gnt_is_wr_reg;   // type of the current/last grant
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              wr_ack_d_reg;
    logic              rd_ack_d_reg;
    logic [WDOG_W-1:0] cnt_reg;
    logic              timeout_reg;
    logic              rr_wr_reg;
    logic              rr_rd_reg;

    logic [1:0]        wr_req_vec, rd_req_vec;
    logic [1:0]        wr_gnt, rd_gnt;
    logic              wdog_hit;
    logic              in_burst;
    logic              wr_phase, rd_phase;
    logic              grant_wr, grant_rd;

    assign wr_req_vec = {ch1_wr_req, ch0_wr_req};
    assign rd_req_vec = {ch1_rd_req, ch0_rd_req};

    sdram_rr_pick u_wr_pick (
        .req (wr_req_vec),
        .ptr (rr_wr_reg),
        .gnt (wr_gnt)
    );

    sdram_rr_pick u_rd_pick (
        .req (rd_req_vec),
        .ptr (rr_rd_reg),
        .gnt (rd_gnt)
    );

    assign in_burst = is_burst_state(state_reg);
    assign wdog_hit = in_burst && (cnt_reg == TO_LIMIT);
    assign wr_phase = (state_reg == WR_REQ) || (state_reg == WR_BUSY);
    assign rd_phase = (state_reg == RD_REQ) || (state_reg == RD_BUSY);

    // Grant decisions taken in IDLE; writes always win over reads.
    assign grant_wr = (state_reg == IDLE) && sdram_init_done && (|wr_req_vec);
    assign grant_rd = (state_reg == IDLE) && sdram_init_done && !(|wr_req_vec)
                      && (|rd_req_vec);

    // ------------------------------------------------------------------ FSM --
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WR_REQ;
                end else if (grant_rd) begin
                    state_next = RD_REQ;
                end
            end
            WR_REQ: begin
                if (wdog_hit) begin
                    state_next = DONE;
                end else if (sdram_wr_ack) begin
                    state_next = WR_BUSY;
                end
            end
            WR_BUSY: begin
                // Burst ends on the falling edge of the controller ack.
                if (wdog_hit || (wr_ack_d_reg && !sdram_wr_ack)) begin
                    state_next = DONE;
                end
            end
            RD_REQ: begin
                if (wdog_hit) begin
                    state_next = DONE;
                end else if (sdram_rd_ack) begin
                    state_next = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (wdog_hit || (rd_ack_d_reg && !sdram_rd_ack)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ch_reg     <= 1'b0;
            rd_ch_reg     <= 1'b0;
            gnt_is_wr_reg <= 1'b0;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            wr_ack_d_reg  <= 1'b0;
            rd_ack_d_reg  <= 1'b0;
            cnt_reg       <= '0;
            timeout_reg   <= 1'b0;
            rr_wr_reg     <= 1'b0;
            rr_rd_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ack_d_reg <= sdram_wr_ack;
            rd_ack_d_reg <= sdram_rd_ack;

            // Capture channel and address at grant; they stay frozen for the
            // whole burst no matter what the requester does afterwards.
            if (grant_wr) begin
                gnt_is_wr_reg <= 1'b1;
                wr_ch_reg     <= wr_gnt[1];
                wr_addr_reg   <= wr_gnt[1] ? ch1_wr_addr : ch0_wr_addr;
                cnt_reg       <= '0;
            end else if (grant_rd) begin
                gnt_is_wr_reg <= 1'b0;
                rd_ch_reg     <= rd_gnt[1];
                rd_addr_reg   <= rd_gnt[1] ? ch1_rd_addr : ch0_rd_addr;
                cnt_reg       <= '0;
            end else if (in_burst) begin
                if (wdog_hit) begin
                    timeout_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Pointer moves past the channel just served, same type only.
            if (state_reg == DONE) begin
                if (gnt_is_wr_reg) begin
                    rr_wr_reg <= ~wr_ch_reg;
                end else begin
                    rr_rd_reg <= ~rd_ch_reg;
                end
            end
        end
    end

    // -------------------------------------------------------------- outputs --
    // Requests decode straight from state so reset removes them at once.
    assign sdram_wr_req  = (state_reg == WR_REQ);
    assign sdram_rd_req  = (state_reg == RD_REQ);
    assign sdram_wr_addr = wr_addr_reg;
    assign sdram_rd_addr = rd_addr_reg;
    assign sdram_din     = wr_ch_reg ? ch1_din : ch0_din;
    assign timeout_err   = timeout_reg;

    // Zero-latency channel acks so FIFOs pop/push in the ack cycle itself.
    logic [1:0] wr_ack_vec, rd_ack_vec;
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch_ack
        assign wr_ack_vec[gi] = sdram_wr_ack && wr_phase && (wr_ch_reg == 1'(gi));
        assign rd_ack_vec[gi] = sdram_rd_ack && rd_phase && (rd_ch_reg == 1'(gi));
    end

    assign ch0_wr_ack = wr_ack_vec[0];
    assign ch1_wr_ack = wr_ack_vec[1];
    assign ch0_rd_ack = rd_ack_vec[0];
    assign ch1_rd_ack = rd_ack_vec[1];

    // Read data goes to both channels; only the acked one consumes it.
    assign ch0_dout = sdram_dout;
    assign ch1_dout = sdram_dout;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed bench: the controller side is driven by hand, one linear sequence.
// Inputs change 2 time units after the rising edge; outputs are sampled there
// (or 1 unit later for combinational acks), never on the edge.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 24;

    logic          clk_ref = 1'b0;
    logic          rst_n;
    logic          sdram_init_done;
    logic          ch0_wr_req, ch1_wr_req, ch0_rd_req, ch1_rd_req;
    logic [AW-1:0] ch0_wr_addr, ch1_wr_addr, ch0_rd_addr, ch1_rd_addr;
    logic [DW-1:0] ch0_din, ch1_din;
    logic          ch0_wr_ack, ch1_wr_ack, ch0_rd_ack, ch1_rd_ack;
    logic [DW-1:0] ch0_dout, ch1_dout;
    logic          sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
    logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
    logic [DW-1:0] sdram_din, sdram_dout;
    logic          timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_ref = ~clk_ref;

    sdram_port_arbiter dut (
        .clk_ref         (clk_ref),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .ch0_wr_req      (ch0_wr_req),
        .ch0_wr_addr     (ch0_wr_addr),
        .ch0_din         (ch0_din),
        .ch0_wr_ack      (ch0_wr_ack),
        .ch1_wr_req      (ch1_wr_req),
        .ch1_wr_addr     (ch1_wr_addr),
        .ch1_din         (ch1_din),
        .ch1_wr_ack      (ch1_wr_ack),
        .ch0_rd_req      (ch0_rd_req),
        .ch0_rd_addr     (ch0_rd_addr),
        .ch0_rd_ack      (ch0_rd_ack),
        .ch0_dout        (ch0_dout),
        .ch1_rd_req      (ch1_rd_req),
        .ch1_rd_addr     (ch1_rd_addr),
        .ch1_rd_ack      (ch1_rd_ack),
        .ch1_dout        (ch1_dout),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_din       (sdram_din),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_dout      (sdram_dout),
        .timeout_err     (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ref);
        #2;
    endtask

    // Bounded wait for a controller request; n = cycles waited, -1 if none.
    task automatic wait_req(input bit is_wr, output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (is_wr ? sdram_wr_req : sdram_rd_req) begin
                n = i;
                break;
            end
        end
    endtask

    // Write burst of len ack cycles; counts channel ack pulses.
    task automatic wr_burst(input int len, output int a0, output int a1);
        a0 = 0;
        a1 = 0;
        for (int i = 0; i < len; i++) begin
            sdram_wr_ack = 1'b1;
            #1;
            if (ch0_wr_ack) a0++;
            if (ch1_wr_ack) a1++;
            step();
        end
        sdram_wr_ack = 1'b0;
    endtask

    int n, a0, a1, tw, seen;
    logic [AW-1:0] rr_exp [4];

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        ch0_wr_req = 0; ch1_wr_req = 0; ch0_rd_req = 0; ch1_rd_req = 0;
        ch0_wr_addr = '0; ch1_wr_addr = '0; ch0_rd_addr = '0; ch1_rd_addr = '0;
        ch0_din = '0; ch1_din = '0;
        sdram_wr_ack = 0; sdram_rd_ack = 0; sdram_dout = '0;
        step(); step();

        // Reset state
        check("rst_wr_req", 64'(sdram_wr_req), 64'd0);
        check("rst_rd_req", 64'(sdram_rd_req), 64'd0);
        check("rst_wr_addr", 64'(sdram_wr_addr), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        $display("reset: wr_req=%0b rd_req=%0b timeout=%0b", sdram_wr_req, sdram_rd_req, timeout_err);
        rst_n = 1'b1;
        step();

        // Init gating: requests high but init_done low -> nothing issued
        ch0_wr_req = 1'b1;
        ch1_rd_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sdram_wr_req || sdram_rd_req) seen++;
        end
        check("init_gate", 64'(seen), 64'd0);
        $display("init gating: request outputs seen=%0d", seen);
        ch0_wr_req = 1'b0;
        ch1_rd_req = 1'b0;
        step();
        sdram_init_done = 1'b1;
        step();

        // Write beats read; ch1 write then ch0 read
        ch0_rd_addr = 24'h001234;
        ch1_wr_addr = 24'h00ABCD;
        ch1_din     = 16'hBEEF;
        ch0_din     = 16'h1111;
        ch0_rd_req  = 1'b1;
        ch1_wr_req  = 1'b1;
        wait_req(1'b1, n);
        check("wr_grant_latency", 64'(n), 64'd1);
        check("prio_wr_addr", 64'(sdram_wr_addr), 64'h00ABCD);
        check("prio_din_mux", 64'(sdram_din), 64'hBEEF);
        check("prio_rd_held", 64'(sdram_rd_req), 64'd0);
        ch1_wr_req = 1'b0;   // dropping the level must not abort the burst
        wr_burst(8, a0, a1);
        check("prio_ch1_acks", 64'(a1), 64'd8);
        check("prio_ch0_acks", 64'(a0), 64'd0);
        $display("priority write: addr=%h ch1_acks=%0d ch0_acks=%0d", sdram_wr_addr, a1, a0);
        // ack falls -> DONE -> IDLE -> RD_REQ
        wait_req(1'b0, n);
        check("rd_after_done", 64'(n), 64'd3);
        check("rd_addr_ch0", 64'(sdram_rd_addr), 64'h001234);
        ch0_rd_req = 1'b0;
        sdram_dout = 16'h5A5A;
        #1;
        check("dout_ch0", 64'(ch0_dout), 64'h5A5A);
        check("dout_ch1", 64'(ch1_dout), 64'h5A5A);
        a0 = 0; a1 = 0;
        for (int i = 0; i < 4; i++) begin
            sdram_rd_ack = 1'b1;
            #1;
            if (ch0_rd_ack) a0++;
            if (ch1_rd_ack) a1++;
            step();
        end
        sdram_rd_ack = 1'b0;
        check("rd_ch0_acks", 64'(a0), 64'd4);
        check("rd_ch1_acks", 64'(a1), 64'd0);
        $display("read: addr=%h ch0_acks=%0d ch1_acks=%0d", sdram_rd_addr, a0, a1);
        step(); step(); step();

        // Write round-robin: both held high, expect ch0, ch1, ch0, ch1
        ch0_wr_addr = 24'h000100;
        ch1_wr_addr = 24'h000300;
        rr_exp[0] = 24'h000100; rr_exp[1] = 24'h000300;
        rr_exp[2] = 24'h000100; rr_exp[3] = 24'h000300;
        ch0_wr_req = 1'b1;
        ch1_wr_req = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_req(1'b1, n);
            check($sformatf("rr_addr_%0d", b), 64'(sdram_wr_addr), 64'(rr_exp[b]));
            if (b == 3) begin
                // release both so no fifth grant follows
                sdram_wr_ack = 1'b1;
                #1;
                a0 = ch0_wr_ack ? 1 : 0;
                a1 = ch1_wr_ack ? 1 : 0;
                step();
                ch0_wr_req = 1'b0;
                ch1_wr_req = 1'b0;
                sdram_wr_ack = 1'b0;
            end else begin
                wr_burst(2, a0, a1);
            end
            check($sformatf("rr_ch1_ack_%0d", b), 64'(a1 != 0), 64'(b % 2));
            $display("rr burst %0d: addr=%h ch0_acks=%0d ch1_acks=%0d", b, sdram_wr_addr, a0, a1);
        end
        step(); step(); step();

        // Address hold: requester address changes mid-burst
        ch0_wr_addr = 24'h000100;
        ch0_wr_req  = 1'b1;
        wait_req(1'b1, n);
        check("hold_grant_addr", 64'(sdram_wr_addr), 64'h000100);
        ch0_wr_req   = 1'b0;
        sdram_wr_ack = 1'b1;
        step();
        ch0_wr_addr = 24'h000200;
        #1;
        check("hold_busy_addr", 64'(sdram_wr_addr), 64'h000100);
        check("busy_no_req", 64'(sdram_wr_req), 64'd0);
        step();
        check("hold_busy_addr2", 64'(sdram_wr_addr), 64'h000100);
        sdram_wr_ack = 1'b0;
        step();
        check("hold_done_addr", 64'(sdram_wr_addr), 64'h000100);
        $display("addr hold: sdram_wr_addr=%h after requester moved to %h", sdram_wr_addr, ch0_wr_addr);
        step(); step();

        // Watchdog: read granted, controller never acks
        ch1_rd_addr = 24'h00FFFF;
        ch1_rd_req  = 1'b1;
        wait_req(1'b0, n);
        check("wd_rd_addr", 64'(sdram_rd_addr), 64'h00FFFF);
        ch1_rd_req = 1'b0;
        check("wd_pre_flag", 64'(timeout_err), 64'd0);
        tw = -1;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (timeout_err) begin
                tw = i;
                break;
            end
        end
        // counter 0..1023 over 1024 burst cycles, flag set on the next edge
        check("wd_cycles", 64'(tw), 64'd1024);
        check("wd_req_dropped", 64'(sdram_rd_req), 64'd0);
        $display("watchdog: timeout_err after %0d cycles", tw);
        ch0_wr_addr = 24'h000400;
        ch0_wr_req  = 1'b1;
        wait_req(1'b1, n);
        check("wd_next_latency", 64'(n), 64'd2);
        check("wd_next_addr", 64'(sdram_wr_addr), 64'h000400);
        check("wd_sticky", 64'(timeout_err), 64'd1);

        // Asynchronous reset mid-burst (in WR_REQ with ack high)
        sdram_wr_ack = 1'b1;
        #1;
        check("pre_rst_ack", 64'(ch0_wr_ack), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_wr_req", 64'(sdram_wr_req), 64'd0);
        check("arst_ch0_ack", 64'(ch0_wr_ack), 64'd0);
        check("arst_wr_addr", 64'(sdram_wr_addr), 64'd0);
        check("arst_rd_addr", 64'(sdram_rd_addr), 64'd0);
        check("arst_timeout", 64'(timeout_err), 64'd0);
        $display("async reset: wr_req=%0b ch0_wr_ack=%0b timeout=%0b", sdram_wr_req, ch0_wr_ack, timeout_err);
        ch0_wr_req   = 1'b0;
        sdram_wr_ack = 1'b0;
        step(); step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (sdram_wr_req || sdram_rd_req) seen++;
        end
        check("no_grant_after_rst", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
